dot_product_sequencer: RTL and testbench
========================================

# dot_product_sequencer

Job-level controller for the AXI-Lite dot-product accelerator. Accepts one job descriptor (A/B/output addresses, vector length), then drives the fetch, compute, write-back and read-back phases in order by pulsing the phase start strobes and waiting on each phase's done flag. It guards every phase with a timeout and supports abort. It returns the read-back result and a sticky error code. It sits above the master/slave pair and replaces ad-hoc start sequencing.

## Interface
- LEN_MAX, 64: largest legal vector length.
- TIMEOUT, 1024: maximum cycles any phase may wait for its done flag.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  job descriptor valid.
- cmd_ready  out  1  sequencer can accept a descriptor.
- cmd_a_addr, cmd_b_addr, cmd_out_addr  in  32 each  job addresses.
- cmd_len  in  32  vector length.
- abort  in  1  cancel the current job.
- start_fetch, start_compute, start_write, start_read  out  1 each  one-cycle phase strobes.
- fetch_done, processing_done, store_done, read_done  in  1 each  phase completion flags (level or pulse).
- rdata_in  in  32  result word; valid in the cycle read_done=1.
- waddr_a, waddr_b, waddr_output, vector_len_o  out  32 each  latched job configuration.
- busy  out  1  a job is in progress.
- result_data  out  32  last read-back result; holds until the next job's result.
- result_valid  out  1  one-cycle pulse when result_data updates.
- error  out  1  sticky error flag.
- err_code  out  2  0 none, 1 bad length, 2 timeout, 3 aborted.
- jobs_done  out  16  count of successful jobs; saturates at 0xFFFF.

## Operation
- States: IDLE, FETCH, COMPUTE, WRITE, READ, DONE, ERR.
- IDLE: cmd_ready=1. cmd_valid&&cmd_ready accepts the job and latches all four config outputs.
  - If cmd_len==0 or cmd_len>LEN_MAX: go to ERR with err_code=1. No strobes fire.
  - Otherwise: go to FETCH. Accepting a job clears error and err_code.
- FETCH/COMPUTE/WRITE/READ: the matching start_* is high only in the first cycle of the state.
  - The done flag is ignored in that first cycle and sampled from the second cycle on.
  - Done seen: advance FETCH→COMPUTE→WRITE→READ→DONE.
  - In READ, rdata_in is captured into result_data on the read_done edge.
- Timeout: the counter clears on entry to each phase and increments every cycle in the phase. If the counter reaches TIMEOUT-1 with no done flag, go to ERR with err_code=2. If done and timeout occur in the same cycle, done wins.
- abort while busy: go to ERR with err_code=3 next cycle. Abort overrides done and timeout. No further strobes fire. abort in IDLE/DONE/ERR is ignored.
- DONE (1 cycle): result_valid=1, jobs_done+1 (saturating), then go to IDLE.
- ERR (1 cycle): error=1 is set, then go to IDLE. error and err_code stay until the next accepted job.
- busy=1 in FETCH, COMPUTE, WRITE and READ only. cmd_ready=1 in IDLE only.
- Config outputs hold their values until the next accepted job.

## Timing
- Reset (rst=0): state IDLE and counter 0. cmd_ready=1; every other output is 0, including all 32-bit registers and jobs_done.
- Reset mid-job clears everything asynchronously. No strobe fires after reset release until a new job is accepted.
- Minimum job (each done arrives in the second cycle of its phase), with acceptance at cycle T:
  - start_fetch T+1, fetch_done T+2.
  - start_compute T+3, done T+4.
  - start_write T+5, done T+6.
  - start_read T+7, read_done T+8.
  - result_valid T+9; cmd_ready back at T+10.
- Each phase adds one cycle per extra cycle of done delay.
- A bad-length job reaches ERR at T+1; error=1 and cmd_ready=1 at T+2.
- A done flag held high past its phase has no effect on later phases, because each phase ignores its own first cycle and only samples its own flag.
- cmd_valid while not ready is not accepted; the descriptor must be held by the source.

## Test plan
- Nominal job: len=4, addresses 0x100/0x200/0x300; each done in the second phase cycle; rdata_in=0x1E. Required: strobes at T+1/3/5/7, result_data=0x1E with result_valid at T+9, jobs_done=1, error=0.
- Bad length: cmd_len=0, then cmd_len=65 (LEN_MAX=64). Required: no strobes, error=1, err_code=1 each time; a following valid job clears error.
- Timeout: TIMEOUT=16, store_done never asserted. Required: ERR after 16 WRITE cycles, err_code=2, start_read never pulses.
- Done and timeout collide: processing_done arrives in exactly the timeout cycle. Required: advance to WRITE, no error.
- Abort in COMPUTE on the same cycle as processing_done. Required: err_code=3, no start_write, busy=0 two cycles later.
- Async reset mid-READ: rst low for 2 cycles. Required: all outputs at reset values immediately, cmd_ready=1, jobs_done=0; the next job runs nominally.

Source files
------------

// File: rtl/dot_product_sequencer_if.sv
// Job/phase handshake bundle between the host environment and the dot-product sequencer.
// "master" is the host side issuing jobs and answering phases; "slave" is the sequencer.
interface dot_product_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a_addr;
    logic [31:0] cmd_b_addr;
    logic [31:0] cmd_out_addr;
    logic [31:0] cmd_len;
    logic        abort;

    logic        start_fetch;
    logic        start_compute;
    logic        start_write;
    logic        start_read;

    logic        fetch_done;
    logic        processing_done;
    logic        store_done;
    logic        read_done;
    logic [31:0] rdata_in;

    modport master (
        output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_out_addr, cmd_len, abort,
        output fetch_done, processing_done, store_done, read_done, rdata_in,
        input  cmd_ready, start_fetch, start_compute, start_write, start_read
    );

    modport slave (
        input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_out_addr, cmd_len, abort,
        input  fetch_done, processing_done, store_done, read_done, rdata_in,
        output cmd_ready, start_fetch, start_compute, start_write, start_read
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// Job-level controller: accepts one descriptor, then runs fetch/compute/write/read phases
// in order with a per-phase timeout, abort, sticky error code and a saturating job counter.
module dot_product_sequencer #(
    parameter int unsigned LEN_MAX = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    dot_product_sequencer_if.slave  bus,
    output logic [31:0]             waddr_a,
    output logic [31:0]             waddr_b,
    output logic [31:0]             waddr_output,
    output logic [31:0]             vector_len_o,
    output logic                    busy,
    output logic [31:0]             result_data,
    output logic                    result_valid,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [15:0]             jobs_done
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_WRITE,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORTED = 2'd3
    } err_t;

    state_t           state;
    state_t           phase_next;
    logic             phase_done;
    logic             phase_active;
    logic [CNT_W-1:0] cnt;
    logic             len_bad;

    // Each phase listens only to its own completion flag.
    always_comb begin
        phase_done   = 1'b0;
        phase_next   = S_IDLE;
        phase_active = 1'b1;
        unique case (state)
            S_FETCH:   begin phase_done = bus.fetch_done;      phase_next = S_COMPUTE; end
            S_COMPUTE: begin phase_done = bus.processing_done; phase_next = S_WRITE;   end
            S_WRITE:   begin phase_done = bus.store_done;      phase_next = S_READ;    end
            S_READ:    begin phase_done = bus.read_done;       phase_next = S_DONE;    end
            default:   phase_active = 1'b0;
        endcase
    end

    assign len_bad = (bus.cmd_len == 32'd0) || (bus.cmd_len > 32'(LEN_MAX));

    // NOTE: every register below is assigned with <= so all updates land together on the
    // clock edge; blocking assignments here would let later lines see half-updated state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            bus.cmd_ready     <= 1'b1;
            bus.start_fetch   <= 1'b0;
            bus.start_compute <= 1'b0;
            bus.start_write   <= 1'b0;
            bus.start_read    <= 1'b0;
            waddr_a           <= '0;
            waddr_b           <= '0;
            waddr_output      <= '0;
            vector_len_o      <= '0;
            busy              <= 1'b0;
            result_data       <= '0;
            result_valid      <= 1'b0;
            error             <= 1'b0;
            err_code          <= ERR_NONE;
            jobs_done         <= '0;
        end else begin
            bus.start_fetch   <= 1'b0;
            bus.start_compute <= 1'b0;
            bus.start_write   <= 1'b0;
            bus.start_read    <= 1'b0;
            result_valid      <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        waddr_a       <= bus.cmd_a_addr;
                        waddr_b       <= bus.cmd_b_addr;
                        waddr_output  <= bus.cmd_out_addr;
                        vector_len_o  <= bus.cmd_len;
                        bus.cmd_ready <= 1'b0;
                        error         <= 1'b0;
                        cnt           <= '0;
                        if (len_bad) begin
                            state    <= S_ERR;
                            err_code <= ERR_BAD_LEN;
                        end else begin
                            state           <= S_FETCH;
                            err_code        <= ERR_NONE;
                            busy            <= 1'b1;
                            bus.start_fetch <= 1'b1;
                        end
                    end
                end

                S_FETCH, S_COMPUTE, S_WRITE, S_READ: begin
                    // cnt==0 marks the strobe cycle, where a stale done flag must be ignored.
                    if (bus.abort) begin
                        state    <= S_ERR;
                        err_code <= ERR_ABORTED;
                        busy     <= 1'b0;
                    end else if (phase_active && phase_done && (cnt != '0)) begin
                        state             <= phase_next;
                        cnt               <= '0;
                        bus.start_compute <= (phase_next == S_COMPUTE);
                        bus.start_write   <= (phase_next == S_WRITE);
                        bus.start_read    <= (phase_next == S_READ);
                        if (phase_next == S_DONE) begin
                            busy         <= 1'b0;
                            result_data  <= bus.rdata_in;
                            result_valid <= 1'b1;
                            if (jobs_done != 16'hFFFF) begin
                                jobs_done <= jobs_done + 16'd1;
                            end
                        end
                    end else if (cnt == CNT_LAST) begin
                        state    <= S_ERR;
                        err_code <= ERR_TIMEOUT;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state         <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                end

                S_ERR: begin
                    state         <= S_IDLE;
                    error         <= 1'b1;
                    bus.cmd_ready <= 1'b1;
                end

                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: nominal job, bad lengths, timeout,
// done/timeout collision, abort racing done, and asynchronous reset mid-READ.
module tb_dot_product_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr_a, waddr_b, waddr_output, vector_len_o;
    logic        busy;
    logic [31:0] result_data;
    logic        result_valid;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] jobs_done;

    dot_product_sequencer_if bus ();

    dot_product_sequencer #(.LEN_MAX(64), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .waddr_a      (waddr_a),
        .waddr_b      (waddr_b),
        .waddr_output (waddr_output),
        .vector_len_o (vector_len_o),
        .busy         (busy),
        .result_data  (result_data),
        .result_valid (result_valid),
        .error        (error),
        .err_code     (err_code),
        .jobs_done    (jobs_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int t0  = 0;
    int fdly = 1, cdly = 1, wdly = 1, rdly = 1;
    int fetch_due = -1, compute_due = -1, write_due = -1, read_due = -1;
    int abort_at = -1;
    int n_fetch, n_compute, n_write, n_read, n_rv;
    int c_fetch, c_compute, c_write, c_read, c_rv;
    logic [31:0] rv_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_log();
        n_fetch = 0; n_compute = 0; n_write = 0; n_read = 0; n_rv = 0;
        c_fetch = -1; c_compute = -1; c_write = -1; c_read = -1; c_rv = -1;
        rv_data = '0;
    endtask

    // One cycle: sample outputs at the falling edge, then drive the responder inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.start_fetch)   begin n_fetch++;   c_fetch   = cyc; fetch_due   = (fdly < 0) ? -1 : cyc + fdly; end
        if (bus.start_compute) begin n_compute++; c_compute = cyc; compute_due = (cdly < 0) ? -1 : cyc + cdly; end
        if (bus.start_write)   begin n_write++;   c_write   = cyc; write_due   = (wdly < 0) ? -1 : cyc + wdly; end
        if (bus.start_read)    begin n_read++;    c_read    = cyc; read_due    = (rdly < 0) ? -1 : cyc + rdly; end
        if (result_valid)      begin n_rv++;      c_rv      = cyc; rv_data     = result_data; end
        bus.fetch_done      = (cyc == fetch_due);
        bus.processing_done = (cyc == compute_due);
        bus.store_done      = (cyc == write_due);
        bus.read_done       = (cyc == read_due);
        bus.abort           = (cyc == abort_at);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] len, input logic [31:0] rd);
        clear_log();
        bus.cmd_a_addr   = a;
        bus.cmd_b_addr   = b;
        bus.cmd_out_addr = o;
        bus.cmd_len      = len;
        bus.rdata_in     = rd;
        bus.cmd_valid    = 1'b1;
        t0 = cyc;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_ready && n < 200);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic check_nominal(input string tag, input logic [31:0] rd, input logic [15:0] jobs);
        check({tag, "_fetch_cyc"},   c_fetch,   t0 + 1);
        check({tag, "_compute_cyc"}, c_compute, t0 + 3);
        check({tag, "_write_cyc"},   c_write,   t0 + 5);
        check({tag, "_read_cyc"},    c_read,    t0 + 7);
        check({tag, "_rv_cyc"},      c_rv,      t0 + 9);
        check({tag, "_ready_cyc"},   cyc,       t0 + 10);
        check({tag, "_rv_count"},    n_rv,      1);
        check({tag, "_rv_data"},     rv_data,   rd);
        check({tag, "_result"},      result_data, rd);
        check({tag, "_jobs"},        32'(jobs_done), 32'(jobs));
        check({tag, "_error"},       32'(error),    32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a_addr = '0; bus.cmd_b_addr = '0; bus.cmd_out_addr = '0; bus.cmd_len = '0;
        bus.abort = 1'b0; bus.rdata_in = '0;
        bus.fetch_done = 1'b0; bus.processing_done = 1'b0; bus.store_done = 1'b0; bus.read_done = 1'b0;
        clear_log();
        repeat (3) tick();

        check("rst_ready",  32'(bus.cmd_ready), 32'd1);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_jobs",   32'(jobs_done), 32'd0);
        check("rst_result", result_data, 32'd0);
        check("rst_errcode", 32'(err_code), 32'd0);
        check("rst_waddr_a", waddr_a, 32'd0);
        rst = 1'b1;
        tick();

        // Nominal job.
        issue(32'h100, 32'h200, 32'h300, 32'd4, 32'h1E);
        check("nom_busy", 32'(busy), 32'd1);
        wait_ready("nom");
        check_nominal("nom", 32'h1E, 16'd1);
        check("nom_waddr_a", waddr_a, 32'h100);
        check("nom_waddr_b", waddr_b, 32'h200);
        check("nom_waddr_o", waddr_output, 32'h300);
        check("nom_len",     vector_len_o, 32'd4);
        check("nom_strobes", n_fetch + n_compute + n_write + n_read, 4);

        // Bad lengths: zero, then LEN_MAX+1.
        issue(32'h10, 32'h20, 32'h30, 32'd0, 32'h0);
        check("len0_ready_t1",  32'(bus.cmd_ready), 32'd0);
        check("len0_code_t1",   32'(err_code), 32'd1);
        tick();
        check("len0_error_t2",  32'(error), 32'd1);
        check("len0_ready_t2",  32'(bus.cmd_ready), 32'd1);
        check("len0_strobes",   n_fetch + n_compute + n_write + n_read, 0);

        issue(32'h11, 32'h21, 32'h31, 32'd65, 32'h0);
        tick();
        check("len65_error",   32'(error), 32'd1);
        check("len65_code",    32'(err_code), 32'd1);
        check("len65_latched", vector_len_o, 32'd65);
        check("len65_strobes", n_fetch + n_compute + n_write + n_read, 0);

        // LEN_MAX itself is legal and clears the sticky error.
        issue(32'h400, 32'h500, 32'h600, 32'd64, 32'hCAFE_0001);
        check("len64_error_cleared", 32'(error), 32'd0);
        check("len64_code_cleared",  32'(err_code), 32'd0);
        wait_ready("len64");
        check_nominal("len64", 32'hCAFE_0001, 16'd2);

        // Timeout in WRITE: store_done never arrives.
        wdly = -1;
        issue(32'h1, 32'h2, 32'h3, 32'd8, 32'hDEAD);
        wait_ready("to");
        wdly = 1;
        check("to_write_cyc", c_write, t0 + 5);
        check("to_ready_cyc", cyc, c_write + 17);
        check("to_code",      32'(err_code), 32'd2);
        check("to_error",     32'(error), 32'd1);
        check("to_no_read",   n_read, 0);
        check("to_jobs",      32'(jobs_done), 32'd2);

        // processing_done lands exactly on the timeout cycle: done wins.
        cdly = 15;
        issue(32'h7, 32'h8, 32'h9, 32'd2, 32'h55);
        wait_ready("coll");
        cdly = 1;
        check("coll_write_cyc", c_write, c_compute + 16);
        check("coll_error",     32'(error), 32'd0);
        check("coll_result",    result_data, 32'h55);
        check("coll_jobs",      32'(jobs_done), 32'd3);

        // Abort in COMPUTE on the same cycle as processing_done.
        issue(32'hA, 32'hB, 32'hC, 32'd3, 32'h77);
        abort_at = t0 + 4;
        repeat (4) tick();
        abort_at = -1;
        check("abort_busy_t5",  32'(busy), 32'd0);
        check("abort_code_t5",  32'(err_code), 32'd3);
        tick();
        check("abort_busy_t6",  32'(busy), 32'd0);
        check("abort_error_t6", 32'(error), 32'd1);
        check("abort_ready_t6", 32'(bus.cmd_ready), 32'd1);
        repeat (4) tick();
        check("abort_no_write", n_write, 0);
        check("abort_jobs",     32'(jobs_done), 32'd3);

        // Asynchronous reset while in READ.
        issue(32'hE0, 32'hE4, 32'hE8, 32'd5, 32'h99);
        repeat (6) tick();
        check("mid_read_strobe", n_read, 1);
        rst = 1'b0;
        #1;
        check("arst_ready",  32'(bus.cmd_ready), 32'd1);
        check("arst_busy",   32'(busy), 32'd0);
        check("arst_jobs",   32'(jobs_done), 32'd0);
        check("arst_result", result_data, 32'd0);
        check("arst_waddr",  waddr_a, 32'd0);
        check("arst_errcode", 32'(err_code), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        clear_log();
        repeat (12) tick();
        check("post_rst_strobes", n_fetch + n_compute + n_write + n_read + n_rv, 0);
        check("post_rst_busy",    32'(busy), 32'd0);

        issue(32'h100, 32'h200, 32'h300, 32'd4, 32'h1234_5678);
        wait_ready("after_rst");
        check_nominal("after_rst", 32'h1234_5678, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
